// File: rtl/rr_arb8_pkg.sv
// Shared constants and state type for the 8-way round-robin arbiter.
// RR_TIMEOUT_EN (consumed by rr_arbiter8) uses MAX_HOLD from here.
package rr_arb8_pkg;

    localparam int NREQ     = 8;
    localparam int IDXW     = 3;
    localparam int MAX_HOLD = 4;
    localparam int HOLDW    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter8_onehot_enc8.sv
// Combinational one-hot to binary encoder for an 8-bit vector; all-zero input encodes to 0.
module onehot_enc8
    import rr_arb8_pkg::*;
(
    input  logic [NREQ-1:0] onehot,
    output logic [IDXW-1:0] idx
);

    // OR-reduction encode is exact for one-hot input and yields 0 for no bits set.
    assign idx[0] = onehot[1] | onehot[3] | onehot[5] | onehot[7];
    assign idx[1] = onehot[2] | onehot[3] | onehot[6] | onehot[7];
    assign idx[2] = onehot[4] | onehot[5] | onehot[6] | onehot[7];

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters; grant is held until done or request drop.
// Optional `RR_TIMEOUT_EN forces release after MAX_HOLD busy cycles and pulses timeout.
module rr_arbiter8
    import rr_arb8_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_valid,
    output logic            timeout
);

    // Handshake: a requester holds req[i] high while it wants the resource; the grant is
    // registered one cycle after arbitration and stays until done=1 or req[grant_idx]=0
    // is sampled at a clock edge, after which the bus is idle for one full cycle.

    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IDXW-1:0] grant_idx_q, grant_idx_d;
    logic [IDXW-1:0] last_q, last_d;
    logic            timeout_q, timeout_d;

    logic [IDXW-1:0] start;
    logic [IDXW-1:0] pos;
    logic [NREQ-1:0] rot_req;
    logic [NREQ-1:0] rot_pick;
    logic [NREQ-1:0] pick_grant;
    logic [IDXW-1:0] pick_idx;
    logic            release_c;
    logic            force_c;

`ifdef RR_TIMEOUT_EN
    logic [HOLDW-1:0] hold_cnt_q, hold_cnt_d;
`endif

    // Rotate so the requester after last sits at bit 0, take the lowest set bit, rotate back.
    assign start    = last_q + IDXW'(1);
    assign rot_pick = rot_req & (~rot_req + NREQ'(1));

    always_comb begin
        pos        = '0;
        rot_req    = '0;
        pick_grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            pos            = IDXW'(i) + start;
            rot_req[i]     = req[pos];
            pick_grant[pos] = rot_pick[i];
        end
    end

    onehot_enc8 u_enc (
        .onehot (pick_grant),
        .idx    (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        last_d      = last_q;
        timeout_d   = 1'b0;
        release_c   = done || !req[grant_idx_q];
        force_c     = 1'b0;
`ifdef RR_TIMEOUT_EN
        hold_cnt_d  = hold_cnt_q;
        force_c     = !release_c && (hold_cnt_q == HOLDW'(MAX_HOLD - 1));
`endif
        case (state_q)
            IDLE: begin
                if (en && (|req)) begin
                    grant_d     = pick_grant;
                    grant_idx_d = pick_idx;
                    state_d     = BUSY;
`ifdef RR_TIMEOUT_EN
                    hold_cnt_d  = '0;
`endif
                end
            end
            BUSY: begin
                if (release_c || force_c) begin
                    grant_d     = '0;
                    grant_idx_d = '0;
                    last_d      = grant_idx_q;
                    state_d     = IDLE;
                    timeout_d   = force_c;
                end else begin
`ifdef RR_TIMEOUT_EN
                    hold_cnt_d  = hold_cnt_q + HOLDW'(1);
`endif
                end
            end
            default: begin
                state_d     = IDLE;
                grant_d     = '0;
                grant_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            last_q      <= IDXW'(NREQ - 1);
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            last_q      <= last_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef RR_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`endif

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = |grant_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios plus random traffic against a behavioural model.
// Honours `RR_TIMEOUT_EN the same way as the design.
module tb_rr_arbiter8;
    import rr_arb8_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int n_tests;
    int n_fail;

    // Behavioural model: owner index (-1 when idle), last served, busy-cycle count
    int m_owner;
    int m_last;
    int m_hold;
    bit m_timeout;

    logic [7:0] exp_q[$];

    rr_arbiter8 dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_last    = 7;
        m_hold    = 0;
        m_timeout = 1'b0;
    endtask

    task automatic model_step();
        bit rel;
        bit forced;
        m_timeout = 1'b0;
        if (m_owner < 0) begin
            if (en && (req != 8'h00)) begin
                for (int k = 1; k <= 8; k++) begin
                    if (req[(m_last + k) % 8]) begin
                        m_owner = (m_last + k) % 8;
                        break;
                    end
                end
                m_hold = 0;
            end
        end else begin
            rel    = done || !req[m_owner];
            forced = 1'b0;
`ifdef RR_TIMEOUT_EN
            forced = !rel && (m_hold == MAX_HOLD - 1);
`endif
            if (rel || forced) begin
                m_last    = m_owner;
                m_owner   = -1;
                m_timeout = forced;
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0] eg;
        logic [7:0] ei;
        eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        ei = (m_owner < 0) ? 8'h00 : 8'(m_owner);
        check({tag, ".grant"}, grant, eg);
        check({tag, ".idx"}, {5'b0, grant_idx}, ei);
        check({tag, ".valid"}, {7'b0, grant_valid}, {7'b0, (m_owner >= 0)});
        check({tag, ".timeout"}, {7'b0, timeout}, {7'b0, m_timeout});
    endtask

    // Drive inputs (called at a negedge), advance through one active edge, sample at the next negedge
    task automatic step(input string tag, input logic e, input logic [7:0] r, input logic d);
        en   = e;
        req  = r;
        done = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic do_reset();
        en   = 1'b0;
        req  = 8'h00;
        done = 1'b0;
        rst  = 1'b1;
        #1;
        model_reset();
        check_outputs("reset_async");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_outputs("reset_done");
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        en      = 1'b0;
        req     = 8'h00;
        done    = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single request, one cycle latency
        step("first", 1'b1, 8'h01, 1'b0);
        check("first_grant_const", grant, 8'h01);
        check("first_valid_const", {7'b0, grant_valid}, 8'h01);

        // Full rotation with done pulsed on every grant
        do_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h00);
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) begin
            step("rr", 1'b1, 8'hFF, (m_owner >= 0));
            if (grant_valid) check("rr_seq_idx", {5'b0, grant_idx}, exp_q.pop_front());
        end
        check("rr_seq_left", 8'(exp_q.size()), 8'h00);

        // Released owner drops to lowest priority
        do_reset();
        step("own3", 1'b1, 8'h08, 1'b0);
        step("own3_rel", 1'b1, 8'h09, 1'b1);
        step("own3_next", 1'b1, 8'h09, 1'b0);
        check("own3_next_idx", {5'b0, grant_idx}, 8'h00);
        step("own0_rel", 1'b1, 8'h09, 1'b1);
        step("own0_next", 1'b1, 8'h09, 1'b0);
        check("own0_next_idx", {5'b0, grant_idx}, 8'h03);

        // Enable gating
        do_reset();
        step("en_off", 1'b0, 8'h10, 1'b0);
        check("en_off_const", grant, 8'h00);
        step("en_on", 1'b1, 8'h10, 1'b0);
        check("en_on_const", grant, 8'h10);
        step("en_off_busy", 1'b0, 8'h10, 1'b0);
        check("en_off_busy_const", grant, 8'h10);

        // Reset while granted, then priority restarts from idx 0
        do_reset();
        step("pre_rst", 1'b1, 8'h20, 1'b0);
        check("pre_rst_const", grant, 8'h20);
        do_reset();
        step("post_rst", 1'b1, 8'hFF, 1'b0);
        check("post_rst_idx", {5'b0, grant_idx}, 8'h00);

`ifdef RR_TIMEOUT_EN
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step("to_hold", 1'b1, 8'h04, 1'b0);
            check("to_hold_const", grant, 8'h04);
        end
        step("to_fire", 1'b1, 8'h04, 1'b0);
        check("to_fire_grant", grant, 8'h00);
        check("to_fire_pulse", {7'b0, timeout}, 8'h01);
        step("to_regrant", 1'b1, 8'h04, 1'b0);
        check("to_regrant_idx", {5'b0, grant_idx}, 8'h02);
        check("to_regrant_pulse", {7'b0, timeout}, 8'h00);
`endif

        // Random traffic
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic       e;
            logic [7:0] r;
            logic       d;
            e = ($urandom_range(0, 9) != 0);
            r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            d = ($urandom_range(0, 3) == 0);
            step("rand", e, r, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
